// File: rtl/htd_down_if.sv
// Handshake/bus bundle for the 3-digit BCD down-counter: load/enable/value in, count and status out.
interface htd_down_if;
   logic       load;
   logic       en;
   logic [3:0] d_hun;
   logic [3:0] d_tens;
   logic [3:0] d_units;
   logic [3:0] hun;
   logic [3:0] tens;
   logic [3:0] units;
   logic       busy;
   logic       zero;
   logic       done;
   logic       err;

   modport master (
      output load, en, d_hun, d_tens, d_units,
      input  hun, tens, units, busy, zero, done, err
   );

   modport slave (
      input  load, en, d_hun, d_tens, d_units,
      output hun, tens, units, busy, zero, done, err
   );
endinterface

// File: rtl/htd_down.sv
// 3-digit BCD down-counter (999..000) with IDLE/RUN/EXPIRED control, optional wrap to 999,
// one-cycle done pulse on reaching 000 by decrement and a sticky invalid-load flag.
module htd_down #(
   parameter bit WRAP = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   htd_down_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      EXPIRED
   } state_t;

   state_t     state;
   logic [3:0] hun_q;
   logic [3:0] tens_q;
   logic [3:0] units_q;
   logic       busy_q;
   logic       done_q;
   logic       err_q;

   logic       load_valid;
   logic       load_zero;
   logic       borrow_units;
   logic       borrow_tens;
   logic [3:0] dec_hun;
   logic [3:0] dec_tens;
   logic [3:0] dec_units;
   logic       dec_to_zero;

   function automatic logic [3:0] dec_digit(input logic [3:0] d);
      return (d == 4'd0) ? 4'd9 : d - 4'd1;
   endfunction

   // Borrow ripples units -> tens -> hundreds only through digits that are already 0.
   always_comb begin
      load_valid   = (bus.d_hun <= 4'd9) && (bus.d_tens <= 4'd9) && (bus.d_units <= 4'd9);
      load_zero    = (bus.d_hun == 4'd0) && (bus.d_tens == 4'd0) && (bus.d_units == 4'd0);
      borrow_units = (units_q == 4'd0);
      borrow_tens  = borrow_units && (tens_q == 4'd0);
      dec_units    = dec_digit(units_q);
      dec_tens     = borrow_units ? dec_digit(tens_q) : tens_q;
      dec_hun      = borrow_tens ? dec_digit(hun_q) : hun_q;
      dec_to_zero  = (dec_hun == 4'd0) && (dec_tens == 4'd0) && (dec_units == 4'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         hun_q   <= 4'd0;
         tens_q  <= 4'd0;
         units_q <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.load) begin
            if (load_valid) begin
               hun_q   <= bus.d_hun;
               tens_q  <= bus.d_tens;
               units_q <= bus.d_units;
               err_q   <= 1'b0;
               if (load_zero && !WRAP) begin
                  state  <= EXPIRED;
                  busy_q <= 1'b0;
               end else begin
                  state  <= RUN;
                  busy_q <= 1'b1;
               end
            end else begin
               err_q <= 1'b1;
            end
         end else if ((state == RUN) && bus.en) begin
            hun_q   <= dec_hun;
            tens_q  <= dec_tens;
            units_q <= dec_units;
            if (dec_to_zero) begin
               done_q <= 1'b1;
               if (!WRAP) begin
                  state  <= EXPIRED;
                  busy_q <= 1'b0;
               end
            end
         end
      end
   end

   assign bus.hun   = hun_q;
   assign bus.tens  = tens_q;
   assign bus.units = units_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;
   assign bus.zero  = (hun_q == 4'd0) && (tens_q == 4'd0) && (units_q == 4'd0);

endmodule

// File: tb/tb_htd_down.sv
// Directed bench for htd_down: one instance without wrap (a) and one with wrap (b).
module tb_htd_down;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   htd_down_if bus_a ();
   htd_down_if bus_b ();

   htd_down #(.WRAP(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   htd_down #(.WRAP(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_stimulus(input bit sel_b, input logic load, input logic en,
                                 input logic [11:0] val);
      if (sel_b) begin
         bus_b.load    = load;
         bus_b.en      = en;
         bus_b.d_hun   = val[11:8];
         bus_b.d_tens  = val[7:4];
         bus_b.d_units = val[3:0];
      end else begin
         bus_a.load    = load;
         bus_a.en      = en;
         bus_a.d_hun   = val[11:8];
         bus_a.d_tens  = val[7:4];
         bus_a.d_units = val[3:0];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count compared as a 12-bit BCD word; flags packed as {busy, zero, done, err}.
   task automatic check_output(input string tag, input bit sel_b,
                               input logic [11:0] exp_cnt, input logic [3:0] exp_flags);
      logic [11:0] obs_cnt;
      logic [3:0]  obs_flags;
      if (sel_b) begin
         obs_cnt   = {bus_b.hun, bus_b.tens, bus_b.units};
         obs_flags = {bus_b.busy, bus_b.zero, bus_b.done, bus_b.err};
      end else begin
         obs_cnt   = {bus_a.hun, bus_a.tens, bus_a.units};
         obs_flags = {bus_a.busy, bus_a.zero, bus_a.done, bus_a.err};
      end
      checks++;
      assert (obs_cnt === exp_cnt) else begin
         errors++;
         $error("[TB] FAIL %s count: observed %h expected %h", tag, obs_cnt, exp_cnt);
      end
      checks++;
      assert (obs_flags === exp_flags) else begin
         errors++;
         $error("[TB] FAIL %s flags(busy,zero,done,err): observed %b expected %b",
                tag, obs_flags, exp_flags);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      apply_stimulus(1'b0, 1'b0, 1'b0, 12'h000);
      apply_stimulus(1'b1, 1'b0, 1'b0, 12'h000);
      #2;
      check_output("reset_a", 1'b0, 12'h000, 4'b0100);
      check_output("reset_b", 1'b1, 12'h000, 4'b0100);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check_output("idle_after_reset", 1'b0, 12'h000, 4'b0100);

      // Count 003 down to expiry with en held for five edges.
      apply_stimulus(1'b0, 1'b1, 1'b0, 12'h003);
      tick(); check_output("load_003", 1'b0, 12'h003, 4'b1000);
      apply_stimulus(1'b0, 1'b0, 1'b1, 12'h000);
      tick(); check_output("dec_002", 1'b0, 12'h002, 4'b1000);
      tick(); check_output("dec_001", 1'b0, 12'h001, 4'b1000);
      tick(); check_output("dec_000_done", 1'b0, 12'h000, 4'b0110);
      tick(); check_output("expired_hold1", 1'b0, 12'h000, 4'b0100);
      tick(); check_output("expired_hold2", 1'b0, 12'h000, 4'b0100);

      // Borrow chain through tens and hundreds, then a load of 000.
      apply_stimulus(1'b0, 1'b1, 1'b0, 12'h100);
      tick(); check_output("load_100", 1'b0, 12'h100, 4'b1000);
      apply_stimulus(1'b0, 1'b0, 1'b1, 12'h000);
      tick(); check_output("borrow_099", 1'b0, 12'h099, 4'b1000);
      apply_stimulus(1'b0, 1'b1, 1'b0, 12'h010);
      tick(); check_output("load_010", 1'b0, 12'h010, 4'b1000);
      apply_stimulus(1'b0, 1'b0, 1'b1, 12'h000);
      tick(); check_output("borrow_009", 1'b0, 12'h009, 4'b1000);
      apply_stimulus(1'b0, 1'b1, 1'b0, 12'h000);
      tick(); check_output("load_000_nodone", 1'b0, 12'h000, 4'b0100);
      apply_stimulus(1'b0, 1'b0, 1'b1, 12'h000);
      tick(); check_output("expired_ignores_en", 1'b0, 12'h000, 4'b0100);

      // Invalid load leaves count/state alone and sets the sticky flag.
      apply_stimulus(1'b0, 1'b1, 1'b0, 12'h250);
      tick(); check_output("load_250", 1'b0, 12'h250, 4'b1000);
      apply_stimulus(1'b0, 1'b1, 1'b0, 12'h25A);
      tick(); check_output("invalid_load", 1'b0, 12'h250, 4'b1001);
      apply_stimulus(1'b0, 1'b0, 1'b0, 12'h000);
      tick(); check_output("err_sticky", 1'b0, 12'h250, 4'b1001);
      apply_stimulus(1'b0, 1'b1, 1'b0, 12'h123);
      tick(); check_output("load_123_clears_err", 1'b0, 12'h123, 4'b1000);

      // Load wins over enable on the same edge; en=0 holds.
      apply_stimulus(1'b0, 1'b1, 1'b1, 12'h500);
      tick(); check_output("load_priority_500", 1'b0, 12'h500, 4'b1000);
      apply_stimulus(1'b0, 1'b0, 1'b0, 12'h000);
      tick(); check_output("hold_500_1", 1'b0, 12'h500, 4'b1000);
      tick(); check_output("hold_500_2", 1'b0, 12'h500, 4'b1000);
      tick(); check_output("hold_500_3", 1'b0, 12'h500, 4'b1000);

      // Wrapping instance: 001 -> 000 (done) -> 999 -> 998 while staying busy.
      apply_stimulus(1'b1, 1'b1, 1'b0, 12'h001);
      tick(); check_output("wrap_load_001", 1'b1, 12'h001, 4'b1000);
      apply_stimulus(1'b1, 1'b0, 1'b1, 12'h000);
      tick(); check_output("wrap_000_done", 1'b1, 12'h000, 4'b1110);
      tick(); check_output("wrap_999", 1'b1, 12'h999, 4'b1000);
      tick(); check_output("wrap_998", 1'b1, 12'h998, 4'b1000);
      apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
      tick(); check_output("wrap_load_000", 1'b1, 12'h000, 4'b1100);
      apply_stimulus(1'b1, 1'b0, 1'b1, 12'h000);
      tick(); check_output("wrap_from_load_999", 1'b1, 12'h999, 4'b1000);
      apply_stimulus(1'b1, 1'b0, 1'b0, 12'h000);

      // Asynchronous reset in the middle of a count at 042.
      apply_stimulus(1'b0, 1'b1, 1'b0, 12'h045);
      tick(); check_output("load_045", 1'b0, 12'h045, 4'b1000);
      apply_stimulus(1'b0, 1'b0, 1'b1, 12'h000);
      tick(); check_output("dec_044", 1'b0, 12'h044, 4'b1000);
      tick(); check_output("dec_043", 1'b0, 12'h043, 4'b1000);
      tick(); check_output("dec_042", 1'b0, 12'h042, 4'b1000);
      #2;
      rst = 1'b0;
      #1;
      check_output("async_reset", 1'b0, 12'h000, 4'b0100);
      @(negedge clk);
      rst = 1'b1;
      tick(); check_output("idle_ignores_en1", 1'b0, 12'h000, 4'b0100);
      tick(); check_output("idle_ignores_en2", 1'b0, 12'h000, 4'b0100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
